// File: rtl/segment_swap_ctl_pkg.sv
// Shared types and constants for the segment swap controller.
package segment_swap_ctl_pkg;

   typedef enum logic [1:0] {RUN_INF, WAIT, RUN_FIN, STOPPED} swap_state_t;

   localparam int unsigned IdxWidthDefault = 15;
   localparam int unsigned RepWidthDefault = 16;

   // Repeat count that selects infinite playback
   localparam logic [RepWidthDefault-1:0] RepInfinite = '1;

   localparam logic Seg0 = 1'b0;
   localparam logic Seg1 = 1'b1;

endpackage

// File: rtl/segment_swap_ctl.sv
// Read-segment swap sequencer for one double-buffered playback datapath.
// Optional SWAP_PULSE output enabled by SEGMENT_SWAP_CTL_SWAP_PULSE_EN.
//
// state   | meaning
// RUN_INF | active segment loops forever, boundaries ignored
// WAIT    | finite request pending, swap at next active-segment boundary
// RUN_FIN | finite segment playing, loops counted at each boundary
// STOPPED | finite repeats exhausted, playback frozen
module segment_swap_ctl
   import segment_swap_ctl_pkg::*;
#(
   parameter int unsigned IdxWidth = IdxWidthDefault,
   parameter int unsigned RepWidth = RepWidthDefault
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                UPDATE,
   input  logic                REQ_SEGMENT,
   input  logic [RepWidth-1:0] REP,
   input  logic [IdxWidth-1:0] CYCLE_0,
   input  logic [IdxWidth-1:0] CYCLE_1,
   input  logic [IdxWidth-1:0] IDX,
   input  logic                IDX_VALID,
   output logic                SEGMENT,
   output logic                STOP,
   output logic                BUSY,
   output logic [RepWidth-1:0] LOOP_CNT
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
   ,
   output logic                SWAP_PULSE
`endif
);

   localparam logic [RepWidth-1:0] RepInf = {RepWidth{1'b1}};

   swap_state_t         state_q, state_d;
   logic                seg_q, seg_d;
   logic                stop_q, stop_d;
   logic                busy_q, busy_d;
   logic [RepWidth-1:0] loop_cnt_q, loop_cnt_d;
   logic [RepWidth-1:0] rep_q, rep_d;
   logic                pend_seg_q, pend_seg_d;
   logic [RepWidth-1:0] pend_rep_q, pend_rep_d;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
   logic                swap_pulse_q, swap_pulse_d;
`endif

   logic [IdxWidth-1:0] cycle_act;
   logic                boundary;

   // CYCLE inputs are live: the compare always uses the current value
   assign cycle_act = (seg_q == Seg1) ? CYCLE_1 : CYCLE_0;
   assign boundary  = IDX_VALID && (IDX == cycle_act);

   always_comb begin
      state_d    = state_q;
      seg_d      = seg_q;
      stop_d     = stop_q;
      busy_d     = busy_q;
      loop_cnt_d = loop_cnt_q;
      rep_d      = rep_q;
      pend_seg_d = pend_seg_q;
      pend_rep_d = pend_rep_q;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
      swap_pulse_d = 1'b0;
`endif

      // An update in the same cycle as a boundary discards the boundary
      if (UPDATE) begin
         if (REP == RepInf) begin
            seg_d      = REQ_SEGMENT;
            stop_d     = 1'b0;
            busy_d     = 1'b0;
            loop_cnt_d = '0;
            state_d    = RUN_INF;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
            swap_pulse_d = 1'b1;
`endif
         end else if (state_q == STOPPED) begin
            seg_d      = REQ_SEGMENT;
            rep_d      = REP;
            loop_cnt_d = '0;
            stop_d     = 1'b0;
            state_d    = RUN_FIN;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
            swap_pulse_d = 1'b1;
`endif
         end else begin
            pend_seg_d = REQ_SEGMENT;
            pend_rep_d = REP;
            busy_d     = 1'b1;
            state_d    = WAIT;
         end
      end else if (boundary) begin
         case (state_q)
            WAIT: begin
               seg_d      = pend_seg_q;
               rep_d      = pend_rep_q;
               loop_cnt_d = '0;
               busy_d     = 1'b0;
               state_d    = RUN_FIN;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
               swap_pulse_d = 1'b1;
`endif
            end
            RUN_FIN: begin
               if (loop_cnt_q == rep_q) begin
                  stop_d  = 1'b1;
                  state_d = STOPPED;
               end else begin
                  loop_cnt_d = loop_cnt_q + RepWidth'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= RUN_INF;
         seg_q      <= Seg0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
         loop_cnt_q <= '0;
         rep_q      <= '0;
         pend_seg_q <= 1'b0;
         pend_rep_q <= '0;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
         swap_pulse_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         seg_q      <= seg_d;
         stop_q     <= stop_d;
         busy_q     <= busy_d;
         loop_cnt_q <= loop_cnt_d;
         rep_q      <= rep_d;
         pend_seg_q <= pend_seg_d;
         pend_rep_q <= pend_rep_d;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
         swap_pulse_q <= swap_pulse_d;
`endif
      end
   end

   assign SEGMENT  = seg_q;
   assign STOP     = stop_q;
   assign BUSY     = busy_q;
   assign LOOP_CNT = loop_cnt_q;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
   assign SWAP_PULSE = swap_pulse_q;
`endif

endmodule

// File: tb/tb_segment_swap_ctl.sv
// Bench for segment_swap_ctl: directed scenarios then random traffic against a play-count model.
module tb_segment_swap_ctl;
   import segment_swap_ctl_pkg::*;

   localparam int IW = 15;
   localparam int RW = 16;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          UPDATE = 1'b0;
   logic          REQ_SEGMENT = 1'b0;
   logic [RW-1:0] REP = '0;
   logic [IW-1:0] CYCLE_0 = IW'(3);
   logic [IW-1:0] CYCLE_1 = IW'(4);
   logic [IW-1:0] IDX = '0;
   logic          IDX_VALID = 1'b0;
   logic          SEGMENT, STOP, BUSY;
   logic [RW-1:0] LOOP_CNT;
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
   logic          SWAP_PULSE;
`endif

   segment_swap_ctl #(.IdxWidth(IW), .RepWidth(RW)) dut (
      .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE), .REQ_SEGMENT(REQ_SEGMENT),
      .REP(REP), .CYCLE_0(CYCLE_0), .CYCLE_1(CYCLE_1), .IDX(IDX),
      .IDX_VALID(IDX_VALID), .SEGMENT(SEGMENT), .STOP(STOP), .BUSY(BUSY),
      .LOOP_CNT(LOOP_CNT)
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
      , .SWAP_PULSE(SWAP_PULSE)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: a finite segment has a number of plays left; it stops when they run out.
   logic m_seg, m_stop, m_busy, m_finite, m_pend_seg, m_swap;
   int   m_left, m_loops, m_pend_rep;

   task automatic model_reset();
      m_seg = 0; m_stop = 0; m_busy = 0; m_finite = 0; m_swap = 0;
      m_left = 0; m_loops = 0; m_pend_seg = 0; m_pend_rep = 0;
   endtask

   task automatic model_step();
      logic bnd;
      bnd = IDX_VALID && (int'(IDX) == (m_seg ? int'(CYCLE_1) : int'(CYCLE_0)));
      m_swap = 0;
      if (UPDATE) begin
         if (REP == RepInfinite) begin
            m_seg = REQ_SEGMENT; m_stop = 0; m_busy = 0; m_loops = 0;
            m_finite = 0; m_swap = 1;
         end else if (m_stop) begin
            m_seg = REQ_SEGMENT; m_left = int'(REP) + 1; m_loops = 0;
            m_stop = 0; m_finite = 1; m_swap = 1;
         end else begin
            m_pend_seg = REQ_SEGMENT; m_pend_rep = int'(REP); m_busy = 1;
         end
      end else if (bnd) begin
         if (m_busy) begin
            m_seg = m_pend_seg; m_left = m_pend_rep + 1; m_loops = 0;
            m_busy = 0; m_finite = 1; m_swap = 1;
         end else if (m_finite && !m_stop) begin
            m_left--;
            if (m_left == 0) m_stop = 1;
            else m_loops++;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".seg"},  32'(SEGMENT),  32'(m_seg));
      check({tag, ".stop"}, 32'(STOP),     32'(m_stop));
      check({tag, ".busy"}, 32'(BUSY),     32'(m_busy));
      check({tag, ".loop"}, 32'(LOOP_CNT), 32'(m_loops));
`ifdef SEGMENT_SWAP_CTL_SWAP_PULSE_EN
      check({tag, ".pulse"}, 32'(SWAP_PULSE), 32'(m_swap));
`endif
   endtask

   task automatic step(input string tag, input logic u, input logic rs, input logic [RW-1:0] rp,
                       input logic v, input int ix);
      UPDATE = u; REQ_SEGMENT = rs; REP = rp; IDX_VALID = v; IDX = IW'(ix);
      model_step();
      @(posedge CLK);
      #1;
      check_all(tag);
   endtask

   initial begin
      int tb_idx;
      int cyc;
      logic u, rs, v;
      logic [RW-1:0] rp;

      model_reset();
      #2;
      check_all("reset");
      #10 RST_N = 1'b1;
      @(posedge CLK); #1;

      // 1: infinite on segment 1, boundaries change nothing
      step("t1.upd", 1, 1, RepInfinite, 0, 0);
      check("t1.seg_is_1", 32'(SEGMENT), 32'd1);
      step("t1.bnd_a", 0, 0, 0, 1, 4);
      step("t1.bnd_b", 0, 0, 0, 1, 4);
      check("t1.seg_hold", 32'(SEGMENT), 32'd1);

      // 2: infinite on segment 0, finite request waits for CYCLE_0 boundary
      step("t2.inf0", 1, 0, RepInfinite, 0, 0);
      step("t2.i0", 0, 0, 0, 1, 0);
      step("t2.req", 1, 1, RW'(1), 1, 1);
      check("t2.busy_set", 32'(BUSY), 32'd1);
      step("t2.i2", 0, 0, 0, 1, 2);
      check("t2.still_seg0", 32'(SEGMENT), 32'd0);
      step("t2.i3", 0, 0, 0, 1, 3);
      check("t2.swapped", 32'(SEGMENT), 32'd1);
      check("t2.busy_clr", 32'(BUSY), 32'd0);

      // 3: rep=1 on segment 1 with CYCLE_1=4 plays twice
      for (int i = 0; i <= 4; i++) step("t3.p1", 0, 0, 0, 1, i);
      check("t3.loop1", 32'(LOOP_CNT), 32'd1);
      for (int i = 0; i <= 4; i++) step("t3.p2", 0, 0, 0, 1, i);
      check("t3.stop", 32'(STOP), 32'd1);
      check("t3.loop_hold", 32'(LOOP_CNT), 32'd1);

      // 4: finite request while stopped swaps at once
      step("t4.upd", 1, 0, RW'(0), 0, 0);
      check("t4.seg0", 32'(SEGMENT), 32'd0);
      check("t4.run", 32'(STOP), 32'd0);
      for (int i = 0; i <= 3; i++) step("t4.play", 0, 0, 0, 1, i);
      check("t4.stop", 32'(STOP), 32'd1);

      // 5: update coincident with a boundary overrides it, last request wins
      step("t5.inf", 1, 0, RepInfinite, 0, 0);
      step("t5.req", 1, 1, RW'(1), 0, 0);
      step("t5.coinc", 1, 0, RW'(2), 1, 3);
      check("t5.no_swap_busy", 32'(BUSY), 32'd1);
      step("t5.bnd", 0, 0, 0, 1, 3);
      check("t5.swap_busy", 32'(BUSY), 32'd0);
      for (int k = 0; k < 3; k++) step("t5.loops", 0, 0, 0, 1, 3);
      check("t5.stop_after3", 32'(STOP), 32'd1);
      check("t5.loop2", 32'(LOOP_CNT), 32'd2);

      // 6: async reset mid-WAIT drops the pending request
      step("t6.inf", 1, 0, RepInfinite, 0, 0);
      step("t6.req", 1, 1, RW'(5), 0, 0);
      UPDATE = 0; IDX_VALID = 0;
      #3 RST_N = 1'b0;
      #1;
      model_reset();
      check_all("t6.async");
      #2 RST_N = 1'b1;
      step("t6.bnd", 0, 0, 0, 1, 3);
      check("t6.no_swap", 32'(BUSY), 32'd0);

      // Random traffic with a free-running timer
      tb_idx = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 63) == 0) CYCLE_0 = IW'($urandom_range(1, 6));
         if ($urandom_range(0, 63) == 0) CYCLE_1 = IW'($urandom_range(1, 6));
         u  = ($urandom_range(0, 11) == 0);
         rs = 1'($urandom_range(0, 1));
         rp = ($urandom_range(0, 3) == 0) ? RepInfinite : RW'($urandom_range(0, 3));
         v  = ($urandom_range(0, 3) != 0);
         cyc = m_seg ? int'(CYCLE_1) : int'(CYCLE_0);
         if ($urandom_range(0, 31) == 0) begin
            step("rnd", u, rs, rp, v, $urandom_range(0, 8));
         end else begin
            step("rnd", u, rs, rp, v, tb_idx);
            if (v) tb_idx = (tb_idx >= cyc) ? 0 : tb_idx + 1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/segment_swap_ctl.md
Name: segment_swap_ctl

Overview:
- Sequences segment selection for one double-buffered playback datapath (modulation or STM; one instance each).
- Takes a host update request (requested read segment plus repeat count) and decides when the read side switches segments:
  - infinite mode: immediately;
  - finite mode: at the current segment's cycle boundary.
- Counts loops of the finite segment and asserts STOP when the repeats are exhausted.
- Sits between the controller register block and the index timer / BRAM read-address mux.

Parameters:
- IdxWidth, 15: width of sample index and cycle values.
- RepWidth, 16: width of repeat count; all-ones means infinite.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- UPDATE  in  1  one-cycle pulse: new segment request valid
- REQ_SEGMENT  in  1  requested read segment
- REP  in  RepWidth  repeat count for the requested segment; sampled with UPDATE
- CYCLE_0  in  IdxWidth  last valid index of segment 0; live value
- CYCLE_1  in  IdxWidth  last valid index of segment 1; live value
- IDX  in  IdxWidth  current read index from the timer
- IDX_VALID  in  1  one-cycle strobe when IDX advances
- SEGMENT  out  1  active read segment
- STOP  out  1  playback of the active segment is frozen
- BUSY  out  1  a finite swap is pending a boundary
- LOOP_CNT  out  RepWidth  completed loops of the current finite segment

Behaviour:
- Clock and reset:
  - One clock CLK.
  - Reset RST_N is asynchronous, active-low.
  - Reset values: SEGMENT=0, STOP=0, BUSY=0, LOOP_CNT=0, state RUN_INF, pending registers=0.
- Outputs are registered. Every reaction appears on the outputs 1 cycle after the triggering input edge.
- Boundary = IDX_VALID && IDX == CYCLE of the active segment (CYCLE_0 or CYCLE_1 selected by SEGMENT).
- States: RUN_INF, WAIT, RUN_FIN, STOPPED.
- UPDATE with REP = all-ones, from any state:
  - SEGMENT<=REQ_SEGMENT, STOP<=0, BUSY<=0, LOOP_CNT<=0, state RUN_INF.
- UPDATE with finite REP while in RUN_INF, WAIT or RUN_FIN:
  - Latch pend_seg<=REQ_SEGMENT and pend_rep<=REP.
  - BUSY<=1, state WAIT. SEGMENT is unchanged.
- UPDATE with finite REP while in STOPPED:
  - No boundary can occur, so swap immediately: SEGMENT<=REQ_SEGMENT, rep<=REP, LOOP_CNT<=0, STOP<=0, state RUN_FIN.
- WAIT on a boundary:
  - SEGMENT<=pend_seg, rep<=pend_rep, LOOP_CNT<=0, BUSY<=0, state RUN_FIN.
- RUN_FIN on a boundary:
  - If LOOP_CNT == rep: STOP<=1, state STOPPED, LOOP_CNT holds.
  - Otherwise LOOP_CNT<=LOOP_CNT+1.
  - The segment therefore plays rep+1 times; REP=0 plays once.
- RUN_INF and STOPPED ignore boundaries.
- Simultaneous UPDATE and boundary in the same cycle: UPDATE wins and the boundary is discarded.
- UPDATE during WAIT: the pending request is overwritten (last wins) and WAIT continues.
- REQ_SEGMENT equal to the active SEGMENT is legal: the segment restarts finite counting at the next boundary.
- A CYCLE change mid-run takes effect on the next compare. No latching.
- IDX > CYCLE never produces a boundary. Such a boundary-less stall is the timer's responsibility, not this block's.
- Reset asserted mid-WAIT discards the pending request.
- LOOP_CNT never wraps: maximum rep is all-ones minus 1.

Optional Feature:
- Macro: SEGMENT_SWAP_CTL_SWAP_PULSE_EN.
- Defined: adds output SWAP_PULSE (1 bit), high for exactly 1 cycle coincident with any SEGMENT register update (immediate or boundary), including same-segment restarts. Reset value 0. Used by the debug output mux.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared params package gets:
  - typedef enum logic [1:0] swap_state_t {RUN_INF, WAIT, RUN_FIN, STOPPED};
  - localparam RepInfinite = all-ones of RepWidth.
- Segment select constants reuse the existing package encodings.
- No sub-module: the boundary comparator is inline. Modulation and STM each instantiate this block with their own IdxWidth.

Test Plan:
1. Reset, then UPDATE REQ_SEGMENT=1 REP=0xFFFF -> next cycle SEGMENT=1, STOP=0, BUSY=0. Boundaries thereafter change nothing.
2. Infinite on segment 0 with CYCLE_0=3; UPDATE REQ_SEGMENT=1 REP=1 at IDX=1 -> BUSY=1 until the IDX_VALID strobe at IDX=3. Next cycle SEGMENT=1, BUSY=0, LOOP_CNT=0.
3. Continuing 2 with CYCLE_1=4 -> first boundary gives LOOP_CNT=1; second boundary gives STOP=1, LOOP_CNT stays 1, SEGMENT stays 1.
4. In STOPPED, UPDATE REQ_SEGMENT=0 REP=0 -> next cycle SEGMENT=0, STOP=0, state RUN_FIN. After one CYCLE_0 boundary, STOP=1.
5. In WAIT, UPDATE arrives on the same cycle as a boundary with REQ_SEGMENT=0 REP=2 -> no swap that cycle, pend_rep=2, BUSY stays 1. Swap happens at the next boundary.
6. Assert RST_N=0 asynchronously mid-WAIT -> outputs return to reset values immediately. After release, a boundary causes no swap.
